// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding one output register.
// Ports: clk, rst (sync, active-high); mode (0 round-robin, 1 fixed),
//   sel (fixed-mode channel); in_valid/in_data/in_ready per channel;
//   out_valid/out_data/out_ch/out_ready for the registered output.
module rr_arb_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
);

    logic [SW-1:0]  ptr;
    logic           load;
    logic           gnt_vld;
    logic [SW-1:0]  gnt_idx;
    logic [W-1:0]   mux_data;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW:0]    sum;
    logic [SW-1:0]  ptr_nxt;

    assign load = ~out_valid | out_ready;

    // Rotating the doubled request vector right by ptr puts the
    // search origin at bit 0, so the lowest set bit is the winner.
    assign dbl = {in_valid, in_valid} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        if (mode) begin
            // sel values with no matching channel grant nothing.
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end else begin
            // Descending scan: the last hit is the lowest offset.
            for (int j = N - 1; j >= 0; j--) begin
                if (rot[j]) begin
                    gnt_vld = 1'b1;
                    sum     = {1'b0, ptr} + (SW+1)'(j);
                end
            end
            if (sum >= (SW+1)'(N)) begin
                sum = sum - (SW+1)'(N);
            end
            gnt_idx = sum[SW-1:0];
        end
    end

    always_comb begin
        mux_data = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                mux_data = in_data[i*W +: W];
            end
            in_ready[i] = ~rst & load & gnt_vld & (gnt_idx == SW'(i));
        end
    end

    assign ptr_nxt = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_ch    <= gnt_idx;
                if (!mode) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
